serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- Receive-side counterpart of the serial transmitter.
- Oversamples the asynchronous rx pin, deframes start, data, optional parity and stop bit(s), and pushes each character into the RX fifo16x9 via a one-clock write request.
- Sits between the rx pin (PMOD) and the RX FIFO inside the serial AXI IP.
- Frame format comes from the same CONTROL fields the transmitter uses (size, parity, stop2, enable).

Parameters:
- OVERSAMPLE, 16, brgen_x pulses per bit time. Power of two, minimum 8.

Ports:
- clk  in  1  system clock (AXI clock)
- reset  in  1  synchronous, active-low reset
- brgen_x  in  1  one-clock pulse at OVERSAMPLE × baud, from a dedicated brd instance
- enable  in  1  CONTROL enable; low forces IDLE
- size  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- parity  in  2  00=none, 01=even, 10=odd, 11=stick-0 (expect parity bit = 0)
- stop2  in  1  1 = two stop bits checked
- rx  in  1  asynchronous serial input, idle high
- full  in  1  RX FIFO full
- wr_data  out  9  {parity_err, char[7:0]}; char is zero-extended for size < 8
- wr_request  out  1  one-clock FIFO push
- framing_error  out  1  one-clock pulse: a stop bit was sampled low
- overrun  out  1  one-clock pulse: character dropped because full=1
- break_det  out  1  one-clock pulse: all data, parity and stop samples were 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- **Reset:** all outputs 0, state IDLE, counters 0, synchroniser flops 1.
- **rx synchroniser:** two flops; rx_s is the second flop. Every reference to rx below means rx_s, which lags the pin by 2 clocks.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- **Tick counter:** a 4-bit (log2 OVERSAMPLE) tick counter advances only on brgen_x.
- **Mid-bit sample point:** the counter reaching OVERSAMPLE-1 within a bit.
- **IDLE:**
  - Stays here while enable=0.
  - On rx=0 with enable=1 → START, with the counter loaded to OVERSAMPLE/2 (mid-start alignment).
- **START:** at the mid-sample:
  - rx=1 → IDLE (false start, no outputs).
  - rx=0 → DATA, bit index 0.
  - size, parity and stop2 are latched here. Changes mid-frame are ignored.
- **DATA:** samples LSB first at each mid-sample.
  - After the last bit (index = size+4) → PARITY if parity≠00, else STOP1.
- **PARITY:** sampled bit compared with the expected value.
  - Even: the XOR over the data bits plus the parity bit must be 0.
  - Odd: that XOR must be 1.
  - Stick-0: the bit must be 0.
  - A mismatch sets parity_err.
- **STOP1:** mid-sample.
  - rx=0 flags a framing error.
  - stop2=1 → STOP2; otherwise the frame completes.
- **STOP2:** mid-sample checked the same way as STOP1; the frame completes.
- **Frame completion:** happens on the clock after the final stop mid-sample tick.
  - full=0 → wr_request=1 for exactly one clock, with wr_data valid that same cycle.
  - full=1 → no push; overrun pulses instead.
  - framing_error and break_det pulse in the same cycle as the push/overrun.
  - A framing-error or break character is still pushed (when not full).
- **Break:** break_det requires all data, parity and stop samples to be 0. break_det implies framing_error.
- **Next state after completion:**
  - Last stop sample low → WAIT_HIGH; stays there until rx=1, then IDLE.
  - Otherwise → IDLE directly, ready for a back-to-back start edge the next clock.
- **enable falling mid-frame:** → IDLE on the next clock. No push, no error pulses, partial character discarded.
- **Synchronous reset mid-frame:** same as above; all pulses suppressed.
- **brgen_x gaps:** brgen_x=0 for long stretches simply freezes the counters. There is no timeout.
- **Output pulse width:** wr_request, framing_error, overrun and break_det are never high for more than one clock.

Decomposition:
- **Shared package (serial_pkg):**
  - SIZE_5..SIZE_8 and PARITY_NONE/EVEN/ODD/STICK0 encodings, shared with the transmitter.
  - rx_state_t enum.
  - CONTROL field positions: ENABLE=4, SIZE=1:0, PARITY=3:2, STOP2=15.
- **Sub-module rx_sync:** two-flop synchroniser with reset value 1, reusable for other async pins. Everything else stays in one module.

Test Plan:
- **8N1, 0x55:** OVERSAMPLE=16, brgen_x every clock; send 0x55 → one wr_request with wr_data=0x055; framing_error, overrun and break_det all 0; busy returns low.
- **7E1, bad parity:** send 0x41 with parity bit 1 (correct value is 0) → wr_data=0x141 (bit8=1), framing_error=0.
- **Framing error, 8N2:** second stop bit driven 0, then rx held low 40 ticks → wr_data=0x0A5, framing_error pulse, FSM holds in WAIT_HIGH until rx=1.
- **False start and break:**
  - 5-tick low glitch → no wr_request, busy back to 0 at the START mid-sample.
  - 0x00 with stop=0 (8N1) → break_det=1, framing_error=1, wr_data=0x000 pushed.
- **Overrun:** full=1 during frame completion of 0x33 → overrun pulses once, no wr_request. Next frame 0xCC with full=0 → pushed normally.
- **Disable and reset mid-frame:**
  - enable dropped at DATA bit 3 → IDLE next clock, no outputs.
  - reset=0 for one clock mid-PARITY → all outputs 0.
  - Following 6O1 frame 0x2A with correct parity (0) → wr_data=0x02A.

Source files
------------

// File: rtl/serial_pkg.sv
// Encodings and types shared by the serial transmitter and receiver.
package serial_pkg;

    localparam logic [1:0] SIZE_5 = 2'b00;
    localparam logic [1:0] SIZE_6 = 2'b01;
    localparam logic [1:0] SIZE_7 = 2'b10;
    localparam logic [1:0] SIZE_8 = 2'b11;

    localparam logic [1:0] PARITY_NONE   = 2'b00;
    localparam logic [1:0] PARITY_EVEN   = 2'b01;
    localparam logic [1:0] PARITY_ODD    = 2'b10;
    localparam logic [1:0] PARITY_STICK0 = 2'b11;

    // CONTROL register field positions
    localparam int CTRL_SIZE_LSB   = 0;
    localparam int CTRL_SIZE_MSB   = 1;
    localparam int CTRL_PARITY_LSB = 2;
    localparam int CTRL_PARITY_MSB = 3;
    localparam int CTRL_ENABLE     = 4;
    localparam int CTRL_STOP2      = 15;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2,
        RX_WAIT_HIGH
    } rx_state_t;

    // Index of the final data bit for a given size field (5..8 bits).
    function automatic logic [2:0] last_bit_index(input logic [1:0] size);
        return {1'b0, size} + 3'd4;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin; resets to RESET_VAL.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial receiver: deframes characters from rx and pushes them
// into the RX FIFO with parity, framing, overrun and break status.
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   RX_IDLE      | waiting for a low level on rx while enabled
//   RX_START     | counting to mid start bit to reject glitches
//   RX_DATA      | sampling data bits LSB first
//   RX_PARITY    | sampling and checking the parity bit
//   RX_STOP1     | sampling the first stop bit
//   RX_STOP2     | sampling the second stop bit (stop2 frames)
//   RX_WAIT_HIGH | line still low after a bad stop; wait for idle
module serial_receiver
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brgen_x,
    input  logic       enable,
    input  logic [1:0] size,
    input  logic [1:0] parity,
    input  logic       stop2,
    input  logic       rx,
    input  logic       full,
    output logic [8:0] wr_data,
    output logic       wr_request,
    output logic       framing_error,
    output logic       overrun,
    output logic       break_det,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2);

    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      data_sr;
    logic [1:0]      size_q;
    logic [1:0]      parity_q;
    logic            stop2_q;
    logic            par_acc;
    logic            parity_err;
    logic            stop_err;
    logic            all_zero;
    logic            mid;
    logic            in_frame;
    logic            last_stop;
    logic            stop_err_n;
    logic            all_zero_n;

    rx_sync #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign mid        = brgen_x && (tick_cnt == TICK_MID);
    assign in_frame   = (state != RX_IDLE) && (state != RX_WAIT_HIGH);
    assign last_stop  = mid && (((state == RX_STOP1) && !stop2_q) || (state == RX_STOP2));
    assign stop_err_n = stop_err | ~rx_s;
    assign all_zero_n = all_zero & ~rx_s;
    assign busy       = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= RX_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            data_sr       <= '0;
            size_q        <= '0;
            parity_q      <= '0;
            stop2_q       <= 1'b0;
            par_acc       <= 1'b0;
            parity_err    <= 1'b0;
            stop_err      <= 1'b0;
            all_zero      <= 1'b0;
            wr_data       <= '0;
            wr_request    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            break_det     <= 1'b0;
        end else begin
            wr_request    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            break_det     <= 1'b0;

            if (!enable) begin
                state    <= RX_IDLE;
                tick_cnt <= '0;
            end else begin
                if (brgen_x && in_frame)
                    tick_cnt <= tick_cnt + 1'b1;

                case (state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            state      <= RX_START;
                            tick_cnt   <= TICK_HALF;
                            data_sr    <= '0;
                            par_acc    <= 1'b0;
                            parity_err <= 1'b0;
                            stop_err   <= 1'b0;
                            all_zero   <= 1'b1;
                        end
                    end
                    RX_START: begin
                        if (mid) begin
                            if (rx_s) begin
                                state <= RX_IDLE;
                            end else begin
                                state    <= RX_DATA;
                                bit_idx  <= '0;
                                size_q   <= size;
                                parity_q <= parity;
                                stop2_q  <= stop2;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (mid) begin
                            data_sr[bit_idx] <= rx_s;
                            par_acc          <= par_acc ^ rx_s;
                            all_zero         <= all_zero_n;
                            if (bit_idx == last_bit_index(size_q))
                                state <= (parity_q == PARITY_NONE) ? RX_STOP1 : RX_PARITY;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        if (mid) begin
                            all_zero <= all_zero_n;
                            case (parity_q)
                                PARITY_EVEN: parity_err <= par_acc ^ rx_s;
                                PARITY_ODD:  parity_err <= ~(par_acc ^ rx_s);
                                default:     parity_err <= rx_s;
                            endcase
                            state <= RX_STOP1;
                        end
                    end
                    RX_STOP1: begin
                        if (mid && stop2_q) begin
                            stop_err <= stop_err_n;
                            all_zero <= all_zero_n;
                            state    <= RX_STOP2;
                        end
                    end
                    RX_STOP2: ;
                    RX_WAIT_HIGH: begin
                        if (rx_s)
                            state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase

                // Final stop sample: report the character and pick the exit state
                if (last_stop) begin
                    if (full) begin
                        overrun <= 1'b1;
                    end else begin
                        wr_request <= 1'b1;
                        wr_data    <= {parity_err, data_sr};
                    end
                    framing_error <= stop_err_n;
                    break_det     <= all_zero_n;
                    state         <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with brgen_x every clock (16 clocks per bit).
module tb_serial_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       brgen_x;
    logic       enable;
    logic [1:0] size;
    logic [1:0] parity;
    logic       stop2;
    logic       rx;
    logic       full;
    logic [8:0] wr_data;
    logic       wr_request;
    logic       framing_error;
    logic       overrun;
    logic       break_det;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int n_wr = 0, n_fe = 0, n_ov = 0, n_brk = 0, pulse_viol = 0;
    logic [8:0] last_data = '0;
    logic p_wr = 1'b0, p_fe = 1'b0, p_ov = 1'b0, p_brk = 1'b0;
    int b_wr, b_fe, b_ov, b_brk;

    always #5 clk = ~clk;

    serial_receiver #(.OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .brgen_x       (brgen_x),
        .enable        (enable),
        .size          (size),
        .parity        (parity),
        .stop2         (stop2),
        .rx            (rx),
        .full          (full),
        .wr_data       (wr_data),
        .wr_request    (wr_request),
        .framing_error (framing_error),
        .overrun       (overrun),
        .break_det     (break_det),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (wr_request) begin
            n_wr      <= n_wr + 1;
            last_data <= wr_data;
        end
        if (framing_error) n_fe  <= n_fe + 1;
        if (overrun)       n_ov  <= n_ov + 1;
        if (break_det)     n_brk <= n_brk + 1;
        if ((wr_request && p_wr) || (framing_error && p_fe) || (overrun && p_ov) || (break_det && p_brk))
            pulse_viol <= pulse_viol + 1;
        p_wr  <= wr_request;
        p_fe  <= framing_error;
        p_ov  <= overrun;
        p_brk <= break_det;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_wr  = n_wr;
        b_fe  = n_fe;
        b_ov  = n_ov;
        b_brk = n_brk;
    endtask

    // Drives n bits of v onto rx, LSB first, one bit time each; rx keeps the last bit.
    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx = v[i];
            ticks(16);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            ticks(1);
            k++;
        end
        chk(tag, int'(busy), 0);
    endtask

    initial begin
        reset   = 1'b0;
        brgen_x = 1'b1;
        enable  = 1'b1;
        size    = 2'b11;
        parity  = 2'b00;
        stop2   = 1'b0;
        rx      = 1'b1;
        full    = 1'b0;
        ticks(4);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_wr_request", int'(wr_request), 0);
        chk("rst_framing", int'(framing_error), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_break", int'(break_det), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        ticks(4);

        // 8N1 0x55
        snap();
        send_bits({1'b1, 8'h55, 1'b0}, 10);
        ticks(4);
        chk("8n1_push_count", n_wr - b_wr, 1);
        chk("8n1_data", int'(last_data), 'h055);
        chk("8n1_framing", n_fe - b_fe, 0);
        chk("8n1_overrun", n_ov - b_ov, 0);
        chk("8n1_break", n_brk - b_brk, 0);
        wait_idle("8n1_busy_idle", 20);

        // 7E1 0x41 with wrong parity bit 1
        size   = 2'b10;
        parity = 2'b01;
        snap();
        send_bits({1'b1, 1'b1, 7'h41, 1'b0}, 10);
        ticks(4);
        chk("7e1_push_count", n_wr - b_wr, 1);
        chk("7e1_data", int'(last_data), 'h141);
        chk("7e1_framing", n_fe - b_fe, 0);

        // 8N2 0xA5 with second stop low, line held low afterwards
        size   = 2'b11;
        parity = 2'b00;
        stop2  = 1'b1;
        snap();
        send_bits({1'b0, 1'b1, 8'hA5, 1'b0}, 11);
        ticks(40);
        chk("8n2_push_count", n_wr - b_wr, 1);
        chk("8n2_data", int'(last_data), 'h0A5);
        chk("8n2_framing", n_fe - b_fe, 1);
        chk("8n2_break", n_brk - b_brk, 0);
        chk("8n2_wait_high_hold", int'(busy), 1);
        rx = 1'b1;
        ticks(4);
        chk("8n2_wait_high_exit", int'(busy), 0);
        stop2 = 1'b0;

        // 5-clock low glitch: false start
        snap();
        rx = 1'b0;
        ticks(5);
        rx = 1'b1;
        chk("glitch_busy_start", int'(busy), 1);
        ticks(10);
        chk("glitch_busy_idle", int'(busy), 0);
        chk("glitch_push_count", n_wr - b_wr, 0);
        chk("glitch_framing", n_fe - b_fe, 0);

        // Break: 0x00 with stop low (8N1)
        snap();
        send_bits(16'h0000, 10);
        rx = 1'b1;
        ticks(4);
        chk("break_det", n_brk - b_brk, 1);
        chk("break_framing", n_fe - b_fe, 1);
        chk("break_push_count", n_wr - b_wr, 1);
        chk("break_data", int'(last_data), 'h000);
        wait_idle("break_busy_idle", 20);

        // Overrun on 0x33, then 0xCC pushed normally
        full = 1'b1;
        snap();
        send_bits({1'b1, 8'h33, 1'b0}, 10);
        ticks(4);
        full = 1'b0;
        chk("ovr_overrun", n_ov - b_ov, 1);
        chk("ovr_push_count", n_wr - b_wr, 0);
        snap();
        send_bits({1'b1, 8'hCC, 1'b0}, 10);
        ticks(4);
        chk("after_ovr_push_count", n_wr - b_wr, 1);
        chk("after_ovr_data", int'(last_data), 'h0CC);
        chk("after_ovr_overrun", n_ov - b_ov, 0);

        // enable dropped during DATA bit 3
        snap();
        send_bits({3'b111, 1'b0}, 4);
        rx = 1'b1;
        ticks(8);
        enable = 1'b0;
        ticks(1);
        chk("disable_busy", int'(busy), 0);
        ticks(120);
        enable = 1'b1;
        ticks(4);
        chk("disable_push_count", n_wr - b_wr, 0);
        chk("disable_framing", n_fe - b_fe, 0);
        chk("disable_busy_after", int'(busy), 0);

        // synchronous reset during PARITY of a 6O1 frame
        size   = 2'b01;
        parity = 2'b10;
        snap();
        send_bits({6'h15, 1'b0}, 7);
        rx = 1'b0;
        ticks(8);
        reset = 1'b0;
        ticks(1);
        chk("midrst_wr_request", int'(wr_request), 0);
        chk("midrst_framing", int'(framing_error), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_break", int'(break_det), 0);
        chk("midrst_wr_data", int'(wr_data), 0);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b1;
        rx    = 1'b1;
        ticks(40);
        chk("midrst_push_count", n_wr - b_wr, 0);
        chk("midrst_fe_count", n_fe - b_fe, 0);

        // 6O1 0x2A, correct odd parity bit 0
        snap();
        send_bits({1'b1, 1'b0, 6'h2A, 1'b0}, 9);
        ticks(4);
        chk("6o1_push_count", n_wr - b_wr, 1);
        chk("6o1_data", int'(last_data), 'h02A);
        chk("6o1_framing", n_fe - b_fe, 0);
        wait_idle("6o1_busy_idle", 20);

        chk("pulse_width", pulse_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
